// File: rtl/uart_wb_bridge_if.sv
// Wishbone B4 pipelined bus bundle between the UART debug bridge (master) and the peripheral fabric.
interface uart_wb_bridge_if #(
  parameter int ADDR_BITS = 32
);
  logic                 o_wb_cyc;
  logic                 o_wb_stb;
  logic                 o_wb_we;
  logic [ADDR_BITS-1:0] o_wb_addr;
  logic [31:0]          o_wb_data;
  logic [31:0]          i_wb_data;
  logic                 i_wb_stall;
  logic                 i_wb_ack;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_data, i_wb_stall, i_wb_ack
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_data, i_wb_stall, i_wb_ack
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART (8N1) command-frame parser driving one Wishbone pipelined master access per frame,
// replying with status or read data on the serial TX line.
module uart_wb_bridge #(
  parameter int WB_ADDR_BITS   = 32,
  parameter int TICKS_PER_BAUD = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  uart_wb_bridge_if.master wb,
  input  logic             i_uart_rx,
  output logic             o_uart_tx
);
  // state    | meaning
  // IDLE     | waiting for command byte
  // ADDR     | collecting 4 address bytes
  // DATA     | collecting 4 write-data bytes
  // BUS_REQ  | cyc+stb asserted until the slave accepts
  // BUS_WAIT | cyc held, waiting for ack
  // RESP     | sending reply bytes
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_BUS_REQ, ST_BUS_WAIT, ST_RESP
  } state_t;

  localparam int TK_W = (TICKS_PER_BAUD > 2) ? $clog2(TICKS_PER_BAUD) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TK_W-1:0] TK_FULL = TK_W'(TICKS_PER_BAUD - 1);
  localparam logic [TK_W-1:0] TK_HALF = TK_W'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  logic            r_rx_busy;
  logic [3:0]      r_rx_bit;
  logic [TK_W-1:0] r_rx_tick;
  logic [7:0]      r_rx_shift;
  logic            r_rx_valid, r_rx_ferr;

  logic            r_tx_busy;
  logic [3:0]      r_tx_bits;
  logic [TK_W-1:0] r_tx_tick;
  logic [8:0]      r_tx_frame;
  logic            r_tx_out;
  logic            w_tx_done, w_tx_ready, w_tx_start;
  logic [7:0]      w_tx_byte;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic            r_we, w_we_nxt;
  logic [31:0]     r_addr_sh, w_addr_nxt;
  logic [31:0]     r_data_sh, w_data_nxt;
  logic [31:0]     r_resp_word, w_resp_nxt;
  logic [2:0]      r_resp_left, w_left_nxt;
  logic            w_bus_ok, w_bus_to;

  // RX bit index: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_bit   <= 4'd0;
      r_rx_tick  <= '0;
      r_rx_shift <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= i_uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_prev && !r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_bit  <= 4'd0;
          r_rx_tick <= TK_HALF;
        end
      end else if (r_rx_tick != '0) begin
        r_rx_tick <= r_rx_tick - TK_W'(1);
      end else begin
        r_rx_tick <= TK_FULL;
        r_rx_bit  <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_sync) r_rx_busy <= 1'b0;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy  <= 1'b0;
          r_rx_valid <= r_rx_sync;
          r_rx_ferr  <= !r_rx_sync;
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
      end
    end
  end

  // A new byte may load on the last stop-bit cycle so bytes go out back to back
  assign w_tx_done  = r_tx_busy && (r_tx_bits == 4'd0) && (r_tx_tick == '0);
  assign w_tx_ready = !r_tx_busy || w_tx_done;
  assign w_tx_byte  = r_resp_word[31:24];

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_bits  <= 4'd0;
      r_tx_tick  <= '0;
      r_tx_frame <= 9'h1ff;
      r_tx_out   <= 1'b1;
    end else if (w_tx_start) begin
      r_tx_busy  <= 1'b1;
      r_tx_bits  <= 4'd9;
      r_tx_tick  <= TK_FULL;
      r_tx_frame <= {1'b1, w_tx_byte};
      r_tx_out   <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_tick != '0) begin
        r_tx_tick <= r_tx_tick - TK_W'(1);
      end else if (r_tx_bits == 4'd0) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_out   <= r_tx_frame[0];
        r_tx_frame <= {1'b1, r_tx_frame[8:1]};
        r_tx_bits  <= r_tx_bits - 4'd1;
        r_tx_tick  <= TK_FULL;
      end
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_to_cnt    <= '0;
      r_we        <= 1'b0;
      r_addr_sh   <= 32'h0;
      r_data_sh   <= 32'h0;
      r_resp_word <= 32'h0;
      r_resp_left <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_to_cnt    <= w_to_nxt;
      r_we        <= w_we_nxt;
      r_addr_sh   <= w_addr_nxt;
      r_data_sh   <= w_data_nxt;
      r_resp_word <= w_resp_nxt;
      r_resp_left <= w_left_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to_cnt;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr_sh;
    w_data_nxt  = r_data_sh;
    w_resp_nxt  = r_resp_word;
    w_left_nxt  = r_resp_left;
    w_tx_start  = 1'b0;
    w_bus_ok    = 1'b0;
    w_bus_to    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_addr_nxt = 32'h0;
        w_data_nxt = 32'h0;
        if (r_rx_valid) begin
          w_cnt_nxt = 2'd3;
          if (r_rx_shift == 8'h01 || r_rx_shift == 8'h02) begin
            w_we_nxt    = (r_rx_shift == 8'h02);
            w_state_nxt = ST_ADDR;
          end else begin
            w_resp_nxt  = {REPLY_NAK, 24'h0};
            w_left_nxt  = 3'd1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (r_rx_ferr) begin
          w_state_nxt = ST_IDLE;
        end else if (r_rx_valid) begin
          w_addr_nxt = {r_addr_sh[23:0], r_rx_shift};
          w_cnt_nxt  = r_cnt - 2'd1;
          if (r_cnt == 2'd0) begin
            w_cnt_nxt   = 2'd3;
            w_to_nxt    = TO_LOAD;
            w_state_nxt = r_we ? ST_DATA : ST_BUS_REQ;
          end
        end
      end
      ST_DATA: begin
        if (r_rx_ferr) begin
          w_state_nxt = ST_IDLE;
        end else if (r_rx_valid) begin
          w_data_nxt = {r_data_sh[23:0], r_rx_shift};
          w_cnt_nxt  = r_cnt - 2'd1;
          if (r_cnt == 2'd0) begin
            w_to_nxt    = TO_LOAD;
            w_state_nxt = ST_BUS_REQ;
          end
        end
      end
      ST_BUS_REQ: begin
        w_to_nxt = r_to_cnt - TO_W'(1);
        if (!wb.i_wb_stall && wb.i_wb_ack) w_bus_ok = 1'b1;
        else if (r_to_cnt == '0)           w_bus_to = 1'b1;
        else if (!wb.i_wb_stall)           w_state_nxt = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        w_to_nxt = r_to_cnt - TO_W'(1);
        if (wb.i_wb_ack)            w_bus_ok = 1'b1;
        else if (r_to_cnt == '0)    w_bus_to = 1'b1;
      end
      ST_RESP: begin
        if (w_tx_ready) begin
          if (r_resp_left != 3'd0) begin
            w_tx_start = 1'b1;
            w_resp_nxt = {r_resp_word[23:0], 8'h00};
            w_left_nxt = r_resp_left - 3'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_bus_ok) begin
      w_resp_nxt  = r_we ? {REPLY_ACK, 24'h0} : wb.i_wb_data;
      w_left_nxt  = r_we ? 3'd1 : 3'd4;
      w_state_nxt = ST_RESP;
    end else if (w_bus_to) begin
      w_resp_nxt  = {REPLY_NAK, 24'h0};
      w_left_nxt  = 3'd1;
      w_state_nxt = ST_RESP;
    end
  end

  assign wb.o_wb_cyc  = (r_state == ST_BUS_REQ) || (r_state == ST_BUS_WAIT);
  assign wb.o_wb_stb  = (r_state == ST_BUS_REQ);
  assign wb.o_wb_we   = r_we;
  assign wb.o_wb_addr = r_addr_sh[WB_ADDR_BITS-1:0];
  assign wb.o_wb_data = r_data_sh;
  assign o_uart_tx    = r_tx_out;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: serial host driver, reply decoder, scripted Wishbone slave and a
// frame-level reference model for replies and bus activity.
module tb_uart_wb_bridge;
  localparam int AW  = 32;
  localparam int TPB = 8;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  always #5 clk = ~clk;

  uart_wb_bridge_if #(.ADDR_BITS(AW)) wb ();

  uart_wb_bridge #(
    .WB_ADDR_BITS(AW), .TICKS_PER_BAUD(TPB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .wb(wb), .i_uart_rx(rx), .o_uart_tx(tx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // slave script and bus observations
  int          stall_left = 0, ack_delay = 0, wait_left = 0, phase = 0;
  bit          never_ack  = 1'b0;
  logic [31:0] rdata      = 32'h0;
  int          n_acc = 0, n_stb = 0, n_cyc = 0, n_unstable = 0;
  logic        obs_we;
  logic [31:0] obs_addr, obs_data;
  logic        prev_stb = 1'b0;

  initial begin
    wb.i_wb_stall = 1'b0;
    wb.i_wb_ack   = 1'b0;
    wb.i_wb_data  = 32'h0;
    forever begin
      @(negedge clk);
      wb.i_wb_stall = 1'b0;
      wb.i_wb_ack   = 1'b0;
      wb.i_wb_data  = $urandom;
      if (rst) begin
        phase = 0;
      end else begin
        if (wb.o_wb_cyc) n_cyc++;
        if (wb.o_wb_stb) begin
          n_stb++;
          if (!prev_stb) begin
            n_acc++;
            obs_we   = wb.o_wb_we;
            obs_addr = wb.o_wb_addr;
            obs_data = wb.o_wb_data;
          end else if (obs_we !== wb.o_wb_we || obs_addr !== wb.o_wb_addr || obs_data !== wb.o_wb_data) begin
            n_unstable++;
          end
          if (stall_left > 0) begin
            wb.i_wb_stall = 1'b1;
            stall_left--;
          end else if (ack_delay == 0) begin
            if (!never_ack) begin
              wb.i_wb_ack  = 1'b1;
              wb.i_wb_data = rdata;
            end
          end else begin
            phase     = 1;
            wait_left = ack_delay;
          end
        end else if (phase == 1 && wb.o_wb_cyc) begin
          wait_left--;
          if (wait_left <= 0) begin
            phase = 0;
            if (!never_ack) begin
              wb.i_wb_ack  = 1'b1;
              wb.i_wb_data = rdata;
            end
          end
        end else begin
          phase = 0;
        end
      end
      prev_stb = wb.o_wb_stb;
    end
  end

  // reply decoder: bytes the DUT sends on its TX line
  logic [7:0] rxq[$];
  int         stop_err = 0;

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (TPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (TPB) @(negedge clk);
            b[i] = tx;
          end
          repeat (TPB) @(negedge clk);
          if (tx !== 1'b1) stop_err++;
          rxq.push_back(b);
        end
      end
    end
  end

  task automatic uart_send(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (TPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_obs();
    n_acc = 0; n_stb = 0; n_cyc = 0; n_unstable = 0;
    rxq.delete();
  endtask

  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd,
                         input int stall, input int dly, input bit nack);
    logic [7:0] exp_q[$];
    logic [7:0] got;
    bit         is_bus;
    int         budget;
    is_bus     = (cmd == 8'h01) || (cmd == 8'h02);
    stall_left = stall;
    ack_delay  = dly;
    never_ack  = nack;
    rdata      = rd;
    clear_obs();
    if (!is_bus || nack)   exp_q.push_back(8'h15);
    else if (cmd == 8'h02) exp_q.push_back(8'h06);
    else for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);

    uart_send(cmd, 1'b1);
    if (is_bus) begin
      for (int i = 3; i >= 0; i--) uart_send(addr[8*i +: 8], 1'b1);
      if (cmd == 8'h02)
        for (int i = 3; i >= 0; i--) uart_send(wdata[8*i +: 8], 1'b1);
    end

    budget = 0;
    while (rxq.size() < exp_q.size() && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_nbytes"}, rxq.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (rxq.size() > 0) got = rxq.pop_front();
      else                got = 8'hxx;
      check({tag, "_reply"}, got, exp_q[i]);
    end
    repeat (3 * TPB) @(negedge clk);
    check({tag, "_extra_bytes"}, rxq.size(), 0);
    check({tag, "_accesses"}, n_acc, is_bus ? 1 : 0);
    if (is_bus) begin
      check({tag, "_we"}, obs_we, (cmd == 8'h02));
      check({tag, "_addr"}, obs_addr, addr);
      if (cmd == 8'h02) check({tag, "_wdata"}, obs_data, wdata);
      check({tag, "_stb_cycles"}, n_stb, stall + 1);
      check({tag, "_cyc_cycles"}, n_cyc, nack ? TO : stall + 1 + dly);
      check({tag, "_stable"}, n_unstable, 0);
    end
  endtask

  initial begin
    int budget;
    logic [7:0]  cmd;
    logic [31:0] a, d, r;
    int          pick;

    repeat (5) @(negedge clk);
    check("rst_cyc",  wb.o_wb_cyc,  1'b0);
    check("rst_stb",  wb.o_wb_stb,  1'b0);
    check("rst_we",   wb.o_wb_we,   1'b0);
    check("rst_addr", wb.o_wb_addr, 32'h0);
    check("rst_data", wb.o_wb_data, 32'h0);
    check("rst_tx",   tx,           1'b1);
    rst = 1'b0;
    repeat (4 * TPB) @(negedge clk);

    run_txn("t1_write", 8'h02, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0);
    run_txn("t2_read_stall", 8'h01, 32'h20, 32'h0, 32'h12345678, 3, 0, 1'b0);
    run_txn("t3_nak", 8'h7F, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn("t3_read", 8'h01, 32'h04, 32'h0, 32'hA5A55A5A, 0, 2, 1'b0);
    run_txn("t4_timeout", 8'h01, 32'h08, 32'h0, 32'h0, 0, 0, 1'b1);

    // partial frame cut short by a framing error
    clear_obs();
    uart_send(8'h01, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'hC3, 1'b0);
    repeat (6 * TPB) @(negedge clk);
    check("t5_ferr_accesses", n_acc, 0);
    check("t5_ferr_bytes", rxq.size(), 0);
    run_txn("t5_read", 8'h01, 32'h0C, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0);

    // reset during a write stuck in BUS_WAIT
    stall_left = 0; ack_delay = 0; never_ack = 1'b1;
    clear_obs();
    uart_send(8'h02, 1'b1);
    for (int i = 0; i < 8; i++) uart_send(8'h11 * i[7:0], 1'b1);
    budget = 0;
    while (!(wb.o_wb_cyc && !wb.o_wb_stb) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("t6_reached_wait", budget < 200, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_cyc", wb.o_wb_cyc, 1'b0);
    check("t6_rst_stb", wb.o_wb_stb, 1'b0);
    check("t6_rst_tx",  tx,          1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("t6_no_reply", rxq.size(), 0);
    run_txn("t6_write_after", 8'h02, 32'h40, 32'h0BADF00D, 32'h0, 2, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      pick = $urandom_range(0, 5);
      if (pick <= 2)      cmd = 8'h01;
      else if (pick <= 4) cmd = 8'h02;
      else                cmd = 8'($urandom_range(3, 255));
      a = $urandom;
      d = $urandom;
      r = $urandom;
      run_txn("rnd", cmd, a, d, r, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0));
    end

    check("tx_stop_bits", stop_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
